// File: rtl/rsa_mult_pkg.sv
// rsa_mult_pkg: shared state encoding and index sizing for the limb multiplier.
package rsa_mult_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/limb_mac.sv
// limb_mac: one WIDTH x WIDTH limb product, shifted into place and added to the accumulator.
module limb_mac #(
    parameter int WIDTH = 32,
    parameter int LIMBS = 4,
    parameter int SW    = 3
) (
    input  logic [WIDTH-1:0]         a_limb,
    input  logic [WIDTH-1:0]         b_limb,
    input  logic [SW-1:0]            shift,
    input  logic [2*LIMBS*WIDTH-1:0] acc_in,
    output logic [2*LIMBS*WIDTH-1:0] acc_out
);

    localparam int ACCW = 2*LIMBS*WIDTH;

    logic [2*WIDTH-1:0] prod;

    assign prod    = {{WIDTH{1'b0}}, a_limb} * {{WIDTH{1'b0}}, b_limb};
    assign acc_out = acc_in + (ACCW'(prod) << (32'(shift) * WIDTH));

endmodule

// File: rtl/limb_multiplier_seq.sv
// limb_multiplier_seq: iterative schoolbook multi-limb unsigned multiplier,
// one limb product per cycle, valid/ready on both sides, one operation in flight.
module limb_multiplier_seq
    import rsa_mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LIMBS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LIMBS*WIDTH-1:0] inp_1,
    input  logic [LIMBS*WIDTH-1:0] inp_2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LIMBS*WIDTH-1:0] out_l,
    output logic [LIMBS*WIDTH-1:0] out_h,
    output logic                   busy
);

    localparam int OPW  = LIMBS*WIDTH;
    localparam int IDXW = idx_w(LIMBS);
    localparam int SW   = IDXW + 1;

    state_t            state;
    logic [OPW-1:0]    a_r, b_r;
    logic [2*OPW-1:0]  acc, acc_next;
    logic [IDXW-1:0]   i, j;
    logic [WIDTH-1:0]  a_limb, b_limb;
    logic              last_i, last_j;

    assign a_limb = WIDTH'(a_r >> (32'(i) * WIDTH));
    assign b_limb = WIDTH'(b_r >> (32'(j) * WIDTH));
    assign last_i = i == IDXW'(LIMBS - 1);
    assign last_j = j == IDXW'(LIMBS - 1);

    limb_mac #(.WIDTH(WIDTH), .LIMBS(LIMBS), .SW(SW)) u_mac (
        .a_limb  (a_limb),
        .b_limb  (b_limb),
        .shift   (SW'(i) + SW'(j)),
        .acc_in  (acc),
        .acc_out (acc_next)
    );

    // out_l/out_h are separate registers so the product holds after the handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_l     <= '0;
            out_h     <= '0;
            acc       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            i         <= '0;
            j         <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r      <= inp_1;
                    b_r      <= inp_2;
                    acc      <= '0;
                    i        <= '0;
                    j        <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    state    <= BUSY;
                end
                BUSY: begin
                    acc <= acc_next;
                    j   <= last_j ? '0 : j + 1'b1;
                    if (last_j && !last_i) i <= i + 1'b1;
                    if (last_j && last_i) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_l     <= acc_next[OPW-1:0];
                        out_h     <= acc_next[2*OPW-1:OPW];
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_limb_multiplier_seq.sv
// tb_limb_multiplier_seq: scoreboarded bench for the 32x4 multiplier plus
// directed checks on 8x2 and 8x1 instances.
module tb_limb_multiplier_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] a, b, out_l, out_h;
    logic         in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [15:0]  a8, b8, out_l8, out_h8;
    logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [7:0]   a1, b1, out_l1, out_h1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_recv   = 0;
    logic [255:0] sb[$];
    logic [255:0] mon_exp;

    limb_multiplier_seq #(.WIDTH(32), .LIMBS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inp_1(a), .inp_2(b), .out_valid(out_valid), .out_ready(out_ready),
        .out_l(out_l), .out_h(out_h), .busy(busy)
    );

    limb_multiplier_seq #(.WIDTH(8), .LIMBS(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .inp_1(a8), .inp_2(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_l(out_l8), .out_h(out_h8), .busy(busy8)
    );

    limb_multiplier_seq #(.WIDTH(8), .LIMBS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .inp_1(a1), .inp_2(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_l(out_l1), .out_h(out_h1), .busy(busy1)
    );

    // scoreboard for the 32x4 instance: push on input handshake, pop on output handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) sb.push_back({128'b0, a} * {128'b0, b});
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_output: got %h, none expected", {out_h, out_l});
                end else begin
                    mon_exp = sb.pop_front();
                    n_recv++;
                    if ({out_h, out_l} !== mon_exp) begin
                        n_fail++;
                        $display("FAIL sb_product: got %h expected %h", {out_h, out_l}, mon_exp);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, out_l, out_h} !== {1'b1, 1'b0, 1'b0, 256'b0}) begin
            n_fail++;
            $display("FAIL reset_main: got rdy=%b vld=%b busy=%b out=%h expected 1 0 0 0",
                     in_ready, out_valid, busy, {out_h, out_l});
        end
        n_checks++;
        if ({in_ready8, out_valid8, busy8, out_l8, out_h8} !== {1'b1, 1'b0, 1'b0, 32'b0}) begin
            n_fail++;
            $display("FAIL reset_w8: got rdy=%b vld=%b busy=%b out=%h expected 1 0 0 0",
                     in_ready8, out_valid8, busy8, {out_h8, out_l8});
        end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_w8l2();
        int lat, nb;
        a8 = 16'hFFFF; b8 = 16'hFFFF; in_valid8 = 1'b1; out_ready8 = 1'b0;
        n_checks++;
        if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL w8_in_ready: got %b expected 1", in_ready8); end
        step();
        in_valid8 = 1'b0;
        lat = 0; nb = 0;
        while (!out_valid8 && lat < 50) begin
            if (busy8) nb++;
            step();
            lat++;
        end
        n_checks++;
        if (lat != 4) begin n_fail++; $display("FAIL w8_latency: got %0d expected 4", lat); end
        n_checks++;
        if (nb != 4) begin n_fail++; $display("FAIL w8_busy_cycles: got %0d expected 4", nb); end
        n_checks++;
        if ({out_h8, out_l8, busy8, in_ready8} !== {16'hFFFE, 16'h0001, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL w8_product: got %h_%h busy=%b rdy=%b expected fffe_0001 0 0",
                     out_h8, out_l8, busy8, in_ready8);
        end
        out_ready8 = 1'b1;
        step();
        n_checks++;
        if ({out_valid8, in_ready8, out_h8, out_l8} !== {1'b0, 1'b1, 16'hFFFE, 16'h0001}) begin
            n_fail++;
            $display("FAIL w8_after_handshake: got vld=%b rdy=%b out=%h_%h expected 0 1 fffe_0001",
                     out_valid8, in_ready8, out_h8, out_l8);
        end
        out_ready8 = 1'b0;
    endtask

    task automatic test_identity();
        int lat;
        logic [127:0] ones;
        ones = '1;
        for (int k = 0; k < 2; k++) begin
            a = (k == 0) ? ones : 128'd1;
            b = (k == 0) ? 128'd1 : ones;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ident_in_ready[%0d]: got %b expected 1", k, in_ready); end
            in_valid = 1'b1; out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 40) begin step(); lat++; end
            n_checks++;
            if (lat != 16) begin n_fail++; $display("FAIL ident_latency[%0d]: got %0d expected 16", k, lat); end
            n_checks++;
            if ({out_h, out_l} !== {128'b0, ones}) begin
                n_fail++;
                $display("FAIL ident_product[%0d]: got %h expected %h", k, {out_h, out_l}, {128'b0, ones});
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int w;
        logic [255:0] exp;
        a = rnd128(); b = rnd128();
        exp = {128'b0, a} * {128'b0, b};
        in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 40) begin step(); w++; end
        a = 128'd11; b = 128'd13; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if ({out_valid, in_ready, out_h, out_l} !== {1'b1, 1'b0, exp}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b out=%h expected 1 0 %h",
                         k, out_valid, in_ready, {out_h, out_l}, exp);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if ({out_valid, in_ready, out_h, out_l} !== {1'b0, 1'b1, exp}) begin
            n_fail++;
            $display("FAIL bp_release: got vld=%b rdy=%b out=%h expected 0 1 %h",
                     out_valid, in_ready, {out_h, out_l}, exp);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({busy, in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_pending_accept: got busy=%b rdy=%b expected 1 0", busy, in_ready);
        end
        w = 0;
        while (sb.size() != 0 && w < 40) begin step(); w++; end
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_async_reset();
        int w, seen;
        a = rnd128() | 128'd1; b = rnd128() | 128'd1;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, out_l, out_h} !== {1'b1, 1'b0, 1'b0, 256'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got rdy=%b vld=%b busy=%b out=%h expected 1 0 0 0",
                     in_ready, out_valid, busy, {out_h, out_l});
        end
        sb.delete();
        step();
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) seen++;
            step();
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL async_no_valid: got %0d valid cycles expected 0", seen); end
        a = 128'd3; b = 128'd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 40) begin step(); w++; end
        n_checks++;
        if ({out_valid, out_h, out_l} !== {1'b1, 128'd0, 128'd15}) begin
            n_fail++;
            $display("FAIL async_next_op: got vld=%b out=%h expected 1 %h", out_valid, {out_h, out_l}, 256'd15);
        end
        step();
    endtask

    task automatic test_random();
        int sent, cyc, r0, sel;
        bit acc;
        sent = 0; cyc = 0; r0 = n_recv;
        in_valid = 1'b0;
        while ((sent < 1000 || sb.size() != 0) && cyc < 60000) begin
            if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                sel = $urandom_range(0, 7);
                a = (sel == 0) ? '1 : (sel == 1) ? '0 : rnd128();
                sel = $urandom_range(0, 7);
                b = (sel == 0) ? '1 : (sel == 1) ? '0 : rnd128();
                in_valid = 1'b1;
            end
            out_ready = $urandom_range(0, 2) != 0;
            acc = in_valid && in_ready;
            step();
            cyc++;
            if (acc) begin sent++; in_valid = 1'b0; end
        end
        out_ready = 1'b0;
        n_checks++;
        if (n_recv - r0 != 1000 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL random_count: got %0d received %0d pending expected 1000 0", n_recv - r0, sb.size());
        end
    endtask

    task automatic test_l1();
        int lat;
        a1 = 8'hFF; b1 = 8'h02; in_valid1 = 1'b1; out_ready1 = 1'b0;
        n_checks++;
        if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL l1_in_ready: got %b expected 1", in_ready1); end
        step();
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 20) begin step(); lat++; end
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL l1_latency: got %0d expected 1", lat); end
        n_checks++;
        if ({out_h1, out_l1} !== 16'h01FE) begin n_fail++; $display("FAIL l1_product: got %h expected 01fe", {out_h1, out_l1}); end
        out_ready1 = 1'b1;
        step();
        n_checks++;
        if ({out_valid1, in_ready1} !== 2'b01) begin
            n_fail++;
            $display("FAIL l1_handshake: got vld=%b rdy=%b expected 0 1", out_valid1, in_ready1);
        end
        out_ready1 = 1'b0;
    endtask

    initial begin
        in_valid = 0; out_ready = 0; a = '0; b = '0;
        in_valid8 = 0; out_ready8 = 0; a8 = '0; b8 = '0;
        in_valid1 = 0; out_ready1 = 0; a1 = '0; b1 = '0;
        test_reset();
        test_w8l2();
        test_identity();
        test_backpressure();
        test_async_reset();
        test_random();
        test_l1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
